// File: rtl/load_store_unit.sv
// Load/store unit feeding a 64-bit big-endian, doubleword-wide DataMemory.
// Sub-doubleword stores are performed as read-modify-write of the enclosing doubleword.
module load_store_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [63:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    unsigned_q, unsigned_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   dbuf_q, dbuf_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_fault_q, resp_fault_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    fault_s;

  // Big-endian: a field of 2^size bytes at offset off ends (LSB) this many bits above bit 0.
  function automatic logic [6:0] lane_shift(input logic [2:0] off, input logic [1:0] size);
    logic [3:0] end_byte;
    end_byte = {1'b0, off} + (4'd1 << size);
    return 7'd64 - {end_byte, 3'b000};
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] dw, input logic [2:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [63:0] f;
    f = (dw >> lane_shift(off, size)) & size_mask(size);
    case (size)
      2'b00:   return uns ? f : {{56{f[7]}}, f[7:0]};
      2'b01:   return uns ? f : {{48{f[15]}}, f[15:0]};
      2'b10:   return uns ? f : {{32{f[31]}}, f[31:0]};
      default: return f;
    endcase
  endfunction

  function automatic logic [63:0] merge_lanes(input logic [63:0] dw, input logic [31:0] wd,
                                              input logic [2:0] off, input logic [1:0] size);
    logic [6:0]  sh;
    logic [63:0] m;
    sh = lane_shift(off, size);
    m  = size_mask(size);
    return (dw & ~(m << sh)) | ((({32'd0, wd}) & m) << sh);
  endfunction

  // Fault detection: out-of-range high address bits or unnatural alignment.
  always_comb begin
    fault_s = |req_addr[63:ADDR_WIDTH];
    case (req_size)
      2'b01:   fault_s = fault_s | req_addr[0];
      2'b10:   fault_s = fault_s | (|req_addr[1:0]);
      2'b11:   fault_s = fault_s | (|req_addr[2:0]);
      default: fault_s = fault_s;
    endcase
  end

  // Next-state, request latching, data buffer and registered response values.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dbuf_d       = dbuf_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr[ADDR_WIDTH-1:0];
          wdata_d    = req_wdata[31:0];
          if (fault_s) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (req_write && (req_size == 2'b11)) begin
            state_d = S_WR;
            dbuf_d  = req_wdata;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        dbuf_d = mem_read_data;
        if (write_q) begin
          state_d = S_MERGE;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extend(mem_read_data, addr_q[2:0], size_q, unsigned_q);
        end
      end
      S_MERGE: begin
        dbuf_d  = merge_lanes(dbuf_q, wdata_q, addr_q[2:0], size_q);
        state_d = S_WR;
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      dbuf_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dbuf_q       <= dbuf_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Strobes are gated by reset so an aborted access can never write memory.
  assign req_ready      = (state_q == S_IDLE);
  assign mem_read       = (state_q == S_RD) && !reset;
  assign mem_write      = (state_q == S_WR) && !reset;
  assign mem_address    = ((state_q == S_RD) || (state_q == S_WR)) ?
                          {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign mem_write_data = (state_q == S_WR) ? dbuf_q : '0;
  assign resp_valid     = resp_valid_q;
  assign resp_fault     = resp_fault_q;
  assign resp_rdata     = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory model,
// directed test-plan cases followed by randomized requests.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [63:0] resp_rdata;
  logic [9:0]  mem_address;
  logic [63:0] mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  logic [7:0]  dmem    [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [63:0] pre_data;

  typedef struct {
    logic        fault;
    logic [63:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [9:0]  addr;
    logic        chk;
    logic [63:0] cval;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic mon_en = 1'b0;

  load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DataMemory: big-endian, combinational read, write on rising edge.
  always_comb begin
    for (int i = 0; i < 8; i++) mem_read_data[63-8*i -: 8] = dmem[int'(mem_address) + i];
  end

  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 8; i++) dmem[int'(pre_addr) + i] <= pre_data[63-8*i -: 8];
    end else if (mem_write) begin
      for (int i = 0; i < 8; i++) dmem[int'(mem_address) + i] <= mem_write_data[63-8*i -: 8];
    end
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: plain byte arithmetic on ref_mem.
  function automatic logic [63:0] ref_load(input int addr, input int n, input logic uns);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = (v << 8) | {56'd0, ref_mem[addr + i]};
    if (n < 8 && !uns && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input int addr, input int n, input logic [63:0] wd);
    for (int i = 0; i < n; i++) ref_mem[addr + i] = wd[8*(n-1-i) +: 8];
  endtask

  task automatic wait_ready(output logic ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready;
    if (!ok) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic chk, input logic [63:0] cval);
    exp_t e;
    int   n;
    logic ok;
    wait_ready(ok);
    if (ok) begin
      n       = 1 << sz;
      e.fault = (addr >= 64'd1024) || ((addr % 64'(n)) != 64'd0);
      e.addr  = addr[9:0] & 10'h3F8;
      e.chk   = chk;
      e.cval  = cval;
      e.acc   = cyc;
      e.rdata = 64'd0;
      if (e.fault) begin
        e.lat = 1; e.nrd = 0; e.nwr = 0;
      end else if (!wr) begin
        e.lat = 2; e.nrd = 1; e.nwr = 0;
        e.rdata = ref_load(int'(addr), n, uns);
      end else begin
        e.lat = (n == 8) ? 2 : 4;
        e.nrd = (n == 8) ? 0 : 1;
        e.nwr = 1;
        ref_store(int'(addr), n, wd);
      end
      sbq.push_back(e);
      req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  // Monitor: strobe accounting, response scoreboard, idle/quiet output checks.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read || mem_write) begin
        if (sbq.size() == 0) check("strobe_without_request", 64'd1, 64'd0);
        else check("mem_address", {54'd0, mem_address}, {54'd0, sbq[0].addr});
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          check("resp_fault", {63'd0, resp_fault}, {63'd0, e.fault});
          check("resp_rdata", resp_rdata, e.rdata);
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
          check("mem_read_count", 64'(rd_cnt), 64'(e.nrd));
          check("mem_write_count", 64'(wr_cnt), 64'(e.nwr));
          if (e.chk) check("resp_rdata_const", resp_rdata, e.cval);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        check("resp_quiet", {63'd0, resp_fault} | resp_rdata, 64'd0);
      end
      if (req_ready)
        check("idle_mem_outputs", {62'd0, mem_read, mem_write} | {54'd0, mem_address} | mem_write_data, 64'd0);
    end
  end

  initial begin
    logic [63:0] dw, addr, wd;
    logic [1:0]  sz;
    logic        ok;
    int          n, r;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    pre_we = 1'b0; pre_addr = 10'd0; pre_data = 64'd0;
    for (int a = 0; a < 128; a++) begin
      dw = {$urandom, $urandom};
      if (a == 0) dw = 64'h1122334455667788;
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 10'(a * 8); pre_data = dw;
      for (int i = 0; i < 8; i++) ref_mem[a*8 + i] = dw[63-8*i -: 8];
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("reset_resp_fault", {63'd0, resp_fault}, 64'd0);
    check("reset_resp_rdata", resp_rdata, 64'd0);
    check("reset_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    check("reset_mem_address", {54'd0, mem_address}, 64'd0);
    mon_en = 1'b1;

    issue(1'b0, 2'b00, 1'b1, 64'h0,   64'd0, 1'b1, 64'h0000000000000011);
    issue(1'b0, 2'b00, 1'b0, 64'h7,   64'd0, 1'b1, 64'hFFFFFFFFFFFFFF88);
    issue(1'b0, 2'b10, 1'b0, 64'h4,   64'd0, 1'b1, 64'h0000000055667788);
    issue(1'b1, 2'b01, 1'b0, 64'h2,   64'h000000000000BEEF, 1'b1, 64'd0);
    issue(1'b0, 2'b11, 1'b0, 64'h0,   64'd0, 1'b1, 64'h1122BEEF55667788);
    issue(1'b1, 2'b11, 1'b0, 64'h3F8, 64'hCAFEF00DDEADBEEF, 1'b1, 64'd0);
    issue(1'b0, 2'b11, 1'b0, 64'h3F8, 64'd0, 1'b1, 64'hCAFEF00DDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 64'h2,   64'd0, 1'b1, 64'd0);
    issue(1'b0, 2'b00, 1'b1, 64'h400, 64'd0, 1'b1, 64'd0);
    issue(1'b0, 2'b11, 1'b0, 64'h3FC, 64'd0, 1'b1, 64'd0);

    // Reset during the WR cycle of a dword store to address 8.
    wait_ready(ok);
    req_write = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 64'h8; req_wdata = {$urandom, $urandom}; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_write", {63'd0, mem_write}, 64'd0);
    check("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", {63'd0, req_ready}, 64'd1);
    repeat (3) @(negedge clk);
    issue(1'b0, 2'b11, 1'b0, 64'h8, 64'd0, 1'b0, 64'd0);

    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom_range(0, 3));
      n  = 1 << sz;
      r  = $urandom_range(0, 9);
      addr = 64'($urandom_range(0, 1023));
      if (r == 0) addr = 64'h400 + addr;
      else if (r == 1) addr = addr | (64'd1 << $urandom_range(10, 63));
      else if (r >= 5) addr = addr & ~64'(n - 1);
      wd = {$urandom, $urandom};
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, wd, 1'b0, 64'd0);
    end

    begin
      int w;
      w = 0;
      while (sbq.size() != 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (sbq.size() != 0) check("pending_responses", 64'(sbq.size()), 64'd0);
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute/memory pipeline stage and DataMemory: it is the direct upstream feeder of DataMemory.
- Accepts one load or store request at a time, in sizes byte, half, word or doubleword.
- Maps each request onto DataMemory's 64-bit big-endian doubleword port.
  - Loads: extracts the addressed field, then sign- or zero-extends it.
  - Stores narrower than a doubleword: read-modify-write of the enclosing doubleword.
- Flags misaligned and out-of-range accesses as faults; a faulted request makes no memory access.

Parameters:
- ADDR_WIDTH, 10, DataMemory byte-address width (1024 bytes). DataMemory's address port is this width.
- DATA_WIDTH, 64, memory and register data width. Fixed at 64; the parameter exists for documentation and assertions only.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-justified (LSBs)
- resp_valid  out  1  one-cycle pulse; request complete
- resp_rdata  out  64  extended load data; 0 for stores and faults
- resp_fault  out  1  qualified by resp_valid: misaligned or out-of-range
- mem_address  out  ADDR_WIDTH  to DataMemory address; always doubleword-aligned (low 3 bits 0)
- mem_write_data  out  64  to DataMemory write_data
- mem_read  out  1  to DataMemory MemRead
- mem_write  out  1  to DataMemory MemWrite
- mem_read_data  in  64  from DataMemory read_data; valid in the same cycle as address

Behaviour:
- DataMemory model:
  - byte-addressed, big-endian;
  - combinational read of 8 bytes at an aligned address;
  - write of 8 bytes on the rising edge when MemWrite=1.
- Byte lane mapping: byte offset k (addr[2:0]) maps to bits [63-8k : 56-8k].
- Internal latches: state; request fields; data buffer dbuf (64 bits).
- Reset: state=IDLE, dbuf=0, resp_valid=0, resp_fault=0, resp_rdata=0.
  - mem_read, mem_write, mem_address, mem_write_data are all 0 in IDLE.
- States:
  - IDLE
    - req_ready=1.
    - Accept on req_valid at a rising edge; latch all req_* fields.
    - Fault condition: req_addr[63:ADDR_WIDTH] != 0, or the address is not naturally aligned (half: addr[0]; word: addr[1:0]; dword: addr[2:0]).
    - Fault -> RESP with the fault flag set.
    - Load -> RD.
    - Store dword -> WR, with dbuf = wdata.
    - Store sub-dword -> RD.
  - RD
    - Drive mem_read=1 and mem_address={addr[ADDR_WIDTH-1:3],3'b000}.
    - Capture mem_read_data into dbuf at the clock edge.
    - Next state: load -> RESP; store -> MERGE.
  - MERGE
    - No memory strobes.
    - dbuf <= dbuf with the addressed lanes replaced by the low 8/16/32 bits of wdata.
    - Next state -> WR.
  - WR
    - Drive mem_write=1, mem_address=aligned address, mem_write_data=dbuf.
    - Next state -> RESP.
  - RESP
    - resp_valid=1 for exactly one cycle; resp_fault as latched.
    - resp_rdata:
      - load, no fault: the extracted field, sign- or zero-extended to 64 bits;
      - otherwise: 0.
    - Next state -> IDLE.
- resp outputs are registered; they are 0 in every state other than RESP.
- Latency, counted from the accepting edge to the cycle with resp_valid high:
  - fault: 1 cycle;
  - load: 2 cycles;
  - dword store: 2 cycles;
  - sub-dword store: 4 cycles.
- No response backpressure: the consumer must take resp in the pulse cycle.
- Back-to-back requests: the next request is accepted in the IDLE cycle that follows RESP, never in RESP itself.
- Reset mid-operation:
  - The state returns to IDLE at the reset edge.
  - mem_write and mem_read are gated with !reset, so no memory write occurs during any cycle in which reset=1.
  - The aborted request produces no response.
- Edge address: a dword access at 0x3F8 is legal; a dword access at 0x3FC is misaligned and faults.
- Address 0x400 and above is out of range and faults.
- req_valid held high while req_ready=0 is ignored. The requester must hold the request until it sees req_ready.

Test Plan:
- Preload dword 0 = 0x1122334455667788; load byte unsigned at addr 0 -> resp_rdata = 0x0000000000000011, resp_valid 2 cycles after accept, exactly one mem_read pulse.
- Same preload; load byte signed at addr 7 -> 0xFFFFFFFFFFFFFF88. Load word signed at addr 4 -> 0x0000000055667788.
- Store half 0xBEEF at addr 2 -> exactly one mem_read and one mem_write; a subsequent dword load at 0 returns 0x1122BEEF55667788; resp_valid 4 cycles after accept.
- Store dword 0xCAFEF00DDEADBEEF at addr 0x3F8 -> single mem_write at address 0x3F8, no mem_read; a readback returns the same value.
- Load word at addr 2 -> resp_fault=1 and resp_rdata=0, 1 cycle after accept, no mem_read or mem_write. Load byte at addr 0x400 -> fault.
- Assert reset during WR of a dword store to addr 8 -> mem_write never high in that cycle, no resp_valid, req_ready=1 the cycle after reset drops, dword 8 unchanged.
